// File: rtl/snn_load_ctrl_pkg.sv
// snn_load_ctrl_pkg: shared state encoding, byte width and address-width helper for the host-link loader
package snn_load_ctrl_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {RX, UNPACK, START, CORE, TX_REQ, TX_WAIT} state_t;
    function automatic int addr_w(input int num_bytes, input int dw);
        return $clog2(num_bytes * BYTE_W / dw);
    endfunction
endpackage

// File: rtl/snn_load_ctrl_if.sv
// snn_load_ctrl_if: uart/RAM/core-facing signal bundle of snn_load_ctrl
interface snn_load_ctrl_if import snn_load_ctrl_pkg::*; #(
    parameter int NUM_BYTES = 98,
    parameter int DW = 1,
    parameter int RESULT_W = 4
);
    localparam int ADDR_W = addr_w(NUM_BYTES, DW);
    logic rx_rdy;
    logic [BYTE_W-1:0] rx_data;
    logic ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic core_start;
    logic core_done;
    logic [RESULT_W-1:0] core_digit;
    logic tx_start;
    logic [BYTE_W-1:0] tx_data;
    logic tx_rdy;
    logic [BYTE_W-1:0] led;
    logic busy;
    logic err_timeout;
    logic err_overrun;
    modport master (
        input rx_rdy, rx_data, core_done, core_digit, tx_rdy,
        output ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data, led, busy, err_timeout, err_overrun
    );
    modport slave (
        output rx_rdy, rx_data, core_done, core_digit, tx_rdy,
        input ram_we, ram_addr, ram_wdata, core_start, tx_start, tx_data, led, busy, err_timeout, err_overrun
    );
endinterface

// File: rtl/snn_load_ctrl_unpack.sv
// snn_byte_unpack: loads a byte and presents it DW bits per cycle, LSB slice first
module snn_byte_unpack import snn_load_ctrl_pkg::*; #(
    parameter int DW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [DW-1:0]     slice_o,
    output logic              last_o
);
    localparam int NSL = BYTE_W / DW;
    localparam int CW = NSL > 1 ? $clog2(NSL) : 1;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        shift_d = load_i ? byte_i : adv_i ? shift_q >> DW : shift_q;
        cnt_d = load_i ? '0 : adv_i ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q <= cnt_d;
        end
    end
    assign slice_o = shift_q[DW-1:0];
    assign last_o = cnt_q == CW'(NSL - 1);
endmodule

// File: rtl/snn_load_ctrl.sv
// snn_load_ctrl: unpacks received bytes into the input RAM, runs snn_core on a full image
// and returns the classified digit over uart_tx, with pending byte, timeout and overrun reporting
module snn_load_ctrl import snn_load_ctrl_pkg::*; #(
    parameter int NUM_BYTES = 98,
    parameter int DW = 1,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int RESULT_W = 4
) (
    input logic clk,
    input logic rst,
    snn_load_ctrl_if.master bus
);
    localparam int ADDR_W = addr_w(NUM_BYTES, DW);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BYTES * BYTE_W / DW - 1);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic pend_q, pend_d;
    logic [BYTE_W-1:0] pend_data_q, pend_data_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic tmo_err_q, tmo_err_d;
    logic ovr_q, ovr_d;
    logic tx_start_q, tx_start_d;
    logic [BYTE_W-1:0] result_q, result_d;
    logic low_seen_q, low_seen_d;
    logic load, last;
    logic [DW-1:0] slice;
    assign load = state_q == RX && (pend_q || bus.rx_rdy);
    snn_byte_unpack #(.DW(DW)) u_unpack (
        .clk(clk),
        .rst(rst),
        .load_i(load),
        .adv_i(state_q == UNPACK),
        .byte_i(pend_q ? pend_data_q : bus.rx_data),
        .slice_o(slice),
        .last_o(last)
    );
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        pend_d = pend_q;
        pend_data_d = pend_data_q;
        tmo_d = '0;
        tmo_err_d = 1'b0;
        tx_start_d = 1'b0;
        result_d = result_q;
        low_seen_d = low_seen_q;
        // a byte dropped in the start cycle still counts as an overrun
        ovr_d = state_q == START ? 1'b0 : ovr_q;
        if (bus.rx_rdy && state_q inside {START, CORE, TX_REQ, TX_WAIT}) ovr_d = 1'b1;
        case (state_q)
            RX: begin
                if (load) begin
                    state_d = UNPACK;
                    pend_d = pend_q && bus.rx_rdy;
                    if (bus.rx_rdy) pend_data_d = bus.rx_data;
                end else if (addr_q != '0) begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                        tmo_d = '0;
                        tmo_err_d = 1'b1;
                        addr_d = '0;
                    end
                end
            end
            UNPACK: begin
                if (bus.rx_rdy && pend_q) ovr_d = 1'b1;
                if (bus.rx_rdy && !pend_q) begin
                    pend_d = 1'b1;
                    pend_data_d = bus.rx_data;
                end
                addr_d = addr_q == LAST ? '0 : addr_q + 1'b1;
                if (last) state_d = addr_q == LAST ? START : RX;
            end
            START: state_d = CORE;
            CORE: begin
                if (bus.core_done) begin
                    result_d = '0;
                    result_d[RESULT_W-1:0] = bus.core_digit;
                    state_d = TX_REQ;
                end
            end
            TX_REQ: begin
                if (bus.tx_rdy) begin
                    tx_start_d = 1'b1;
                    low_seen_d = 1'b0;
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!bus.tx_rdy) low_seen_d = 1'b1;
                if (bus.tx_rdy && low_seen_q) begin
                    low_seen_d = 1'b0;
                    addr_d = '0;
                    state_d = RX;
                end
            end
            default: state_d = RX;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX;
            addr_q <= '0;
            pend_q <= 1'b0;
            pend_data_q <= '0;
            tmo_q <= '0;
            tmo_err_q <= 1'b0;
            ovr_q <= 1'b0;
            tx_start_q <= 1'b0;
            result_q <= '0;
            low_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            pend_q <= pend_d;
            pend_data_q <= pend_data_d;
            tmo_q <= tmo_d;
            tmo_err_q <= tmo_err_d;
            ovr_q <= ovr_d;
            tx_start_q <= tx_start_d;
            result_q <= result_d;
            low_seen_q <= low_seen_d;
        end
    end
    assign bus.ram_we = state_q == UNPACK;
    assign bus.ram_addr = addr_q;
    assign bus.ram_wdata = slice;
    assign bus.core_start = state_q == START;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data = result_q;
    assign bus.led = result_q;
    assign bus.busy = state_q != RX;
    assign bus.err_timeout = tmo_err_q;
    assign bus.err_overrun = ovr_q;
endmodule

// File: tb/tb_snn_load_ctrl.sv
// tb_snn_load_ctrl: directed sequence with random image bytes, checked against an image-level byte model
module tb_snn_load_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0, cyc = 0;
    int cs0_n = 0, cs0_cyc = 0, te0_n = 0;
    int ws, cs, te, bad;
    logic [3:0] d;
    logic [7:0] img0 [98];
    logic [7:0] img1 [4];
    logic shadow0 [784];
    logic [1:0] shadow1 [16];
    int wa0[$], wd0[$], wc0[$], wa1[$], wd1[$];
    int exp_a5[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    snn_load_ctrl_if #(.NUM_BYTES(98), .DW(1), .RESULT_W(4)) b0 ();
    snn_load_ctrl_if #(.NUM_BYTES(4), .DW(2), .RESULT_W(4)) b1 ();
    snn_load_ctrl #(.NUM_BYTES(98), .DW(1), .TIMEOUT_CYC(100), .RESULT_W(4)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    snn_load_ctrl #(.NUM_BYTES(4), .DW(2), .TIMEOUT_CYC(100), .RESULT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (b0.ram_we === 1'b1) begin
            wa0.push_back(int'(b0.ram_addr));
            wd0.push_back(int'(b0.ram_wdata));
            wc0.push_back(cyc);
            shadow0[b0.ram_addr] = b0.ram_wdata;
        end
        if (b1.ram_we === 1'b1) begin
            wa1.push_back(int'(b1.ram_addr));
            wd1.push_back(int'(b1.ram_wdata));
            shadow1[b1.ram_addr] = b1.ram_wdata;
        end
        if (b0.core_start === 1'b1) begin
            cs0_n++;
            cs0_cyc = cyc;
        end
        if (b0.err_timeout === 1'b1) te0_n++;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit u, input logic [7:0] b);
        if (u) begin
            b1.rx_data = b;
            b1.rx_rdy = 1'b1;
        end else begin
            b0.rx_data = b;
            b0.rx_rdy = 1'b1;
        end
        step(1);
        b0.rx_rdy = 1'b0;
        b1.rx_rdy = 1'b0;
    endtask

    task automatic load0(input int from, input logic [7:0] fixed, input bit rnd);
        for (int k = from; k < 98; k++) begin
            img0[k] = rnd ? 8'($urandom) : fixed;
            send(1'b0, img0[k]);
            if (k != 97) step(9);
        end
    endtask

    task automatic wait_cs(input bit u, input string tag);
        int n = 0;
        while ((u ? b1.core_start : b0.core_start) !== 1'b1 && n < 200) begin
            step(1);
            n++;
        end
        check(tag, 32'(u ? b1.core_start : b0.core_start), 1);
    endtask

    task automatic check_img0(input string tag);
        int nbad = 0;
        for (int i = 0; i < 784; i++) if (shadow0[i] !== img0[i / 8][i % 8]) nbad++;
        check(tag, 32'(nbad), 0);
    endtask

    task automatic check_stream0(input int start, input string tag);
        int nbad = 0;
        check({tag, "_nwr"}, 32'(wa0.size() - start), 784);
        for (int i = 0; i < 784 && start + i < wa0.size(); i++) if (wa0[start + i] != i) nbad++;
        check({tag, "_addrseq"}, 32'(nbad), 0);
    endtask

    task automatic tx_handshake(input string tag);
        step(1);
        b0.tx_rdy = 1'b0;
        step(4);
        check({tag, "_busy_txwait"}, 32'(b0.busy), 1);
        b0.tx_rdy = 1'b1;
        step(1);
        check({tag, "_idle_after_tx"}, 32'({b0.busy, b0.ram_addr}), 0);
    endtask

    initial begin
        b0.rx_rdy = 0; b0.rx_data = 0; b0.core_done = 0; b0.core_digit = 0; b0.tx_rdy = 1;
        b1.rx_rdy = 0; b1.rx_data = 0; b1.core_done = 0; b1.core_digit = 0; b1.tx_rdy = 1;
        step(3);
        check("rst_ctrl", 32'({b0.ram_we, b0.core_start, b0.tx_start, b0.busy, b0.err_timeout, b0.err_overrun}), 0);
        check("rst_data", 32'({b0.led, b0.tx_data, b0.ram_addr}), 0);
        rst = 1'b0;
        step(2);
        // DW=2 instance: 0xE4 unpacks to 0,1,2,3, then a random full image
        ws = wa1.size();
        img1[0] = 8'hE4;
        send(1'b1, img1[0]);
        step(6);
        check("dw2_nwr", 32'(wa1.size() - ws), 4);
        bad = 0;
        for (int i = 0; i < 4 && ws + i < wa1.size(); i++) if (wa1[ws + i] != i || wd1[ws + i] != i) bad++;
        check("dw2_e4_slices", 32'(bad), 0);
        for (int k = 1; k < 4; k++) begin
            img1[k] = 8'($urandom);
            send(1'b1, img1[k]);
            if (k != 3) step(5);
        end
        wait_cs(1'b1, "dw2_core_start");
        bad = 0;
        for (int i = 0; i < 16; i++) if (32'(shadow1[i]) !== 32'((img1[i / 4] >> (2 * (i % 4))) & 8'h3)) bad++;
        check("dw2_image", 32'(bad), 0);
        // 98 x 0xA5
        ws = wa0.size();
        cs = cs0_n;
        load0(0, 8'hA5, 1'b0);
        wait_cs(1'b0, "t1_core_start");
        check("t1_addr_wrapped", 32'(b0.ram_addr), 0);
        step(1);
        check_stream0(ws, "t1");
        bad = 0;
        for (int i = 0; i < 784 && ws + i < wd0.size(); i++) if (wd0[ws + i] != exp_a5[i % 8]) bad++;
        check("t1_bits", 32'(bad), 0);
        check("t1_start_once", 32'(cs0_n - cs), 1);
        check("t1_start_after_last", 32'(cs0_cyc - wc0[wc0.size() - 1]), 1);
        // result 7 with uart idle
        check("t2_core_wait", 32'({b0.busy, b0.tx_start}), 32'b10);
        b0.core_digit = 4'd7;
        b0.core_done = 1'b1;
        step(1);
        b0.core_done = 1'b0;
        b0.core_digit = 4'hF;
        check("t2_no_early_tx", 32'(b0.tx_start), 0);
        step(1);
        check("t2_tx_start", 32'(b0.tx_start), 1);
        check("t2_tx_data", 32'(b0.tx_data), 32'h07);
        check("t2_led", 32'(b0.led), 32'h07);
        tx_handshake("t2");
        check("t2_led_held", 32'(b0.led), 32'h07);
        send(1'b0, 8'($urandom));
        check("t2_next_byte_addr0", 32'({b0.ram_we, b0.ram_addr}), 32'h400);
        step(9);
        // partial image: short gap keeps it, long gap times out
        for (int k = 1; k < 5; k++) begin
            send(1'b0, 8'($urandom));
            step(9);
        end
        te = te0_n;
        step(80);
        for (int k = 5; k < 10; k++) begin
            send(1'b0, 8'($urandom));
            step(9);
        end
        check("t4_no_early_timeout", 32'(te0_n - te), 0);
        check("t4_partial_addr", 32'(b0.ram_addr), 80);
        cs = cs0_n;
        te = te0_n;
        step(150);
        check("t4_timeout_once", 32'(te0_n - te), 1);
        check("t4_addr_cleared", 32'(b0.ram_addr), 0);
        check("t4_no_core_start", 32'(cs0_n - cs), 0);
        // two bytes during one unpack: first buffered, second dropped
        ws = wa0.size();
        img0[0] = 8'($urandom);
        send(1'b0, img0[0]);
        check("t5_first_addr0", 32'({b0.ram_we, b0.ram_addr}), 32'h400);
        img0[1] = 8'($urandom);
        send(1'b0, img0[1]);
        check("t5_buffered_no_ovr", 32'(b0.err_overrun), 0);
        send(1'b0, 8'($urandom));
        check("t5_overrun_set", 32'(b0.err_overrun), 1);
        step(20);
        check("t5_buffered_written", 32'({b0.busy, b0.ram_addr}), 16);
        load0(2, 8'h00, 1'b1);
        wait_cs(1'b0, "t5_core_start");
        check("t5_ovr_held", 32'(b0.err_overrun), 1);
        step(1);
        check("t5_ovr_cleared", 32'(b0.err_overrun), 0);
        check_img0("t5_image");
        check_stream0(ws, "t5");
        // byte during CORE is dropped
        ws = wa0.size();
        send(1'b0, 8'($urandom));
        check("core_drop_ovr", 32'(b0.err_overrun), 1);
        step(10);
        check("core_drop_nowrite", 32'(wa0.size() - ws), 0);
        d = 4'($urandom_range(15, 1));
        b0.core_digit = d;
        b0.core_done = 1'b1;
        step(1);
        b0.core_done = 1'b0;
        check("core_led_rand", 32'(b0.led), 32'(d));
        tx_handshake("t3");
        // reset in the middle of an unpack
        send(1'b0, 8'($urandom));
        step(2);
        check("t6_mid_unpack", 32'(b0.ram_we), 1);
        rst = 1'b1;
        step(1);
        check("t6_rst_ctrl", 32'({b0.ram_we, b0.core_start, b0.tx_start, b0.busy, b0.err_timeout, b0.err_overrun}), 0);
        check("t6_rst_data", 32'({b0.led, b0.tx_data, b0.ram_addr}), 0);
        rst = 1'b0;
        step(1);
        ws = wa0.size();
        cs = cs0_n;
        load0(0, 8'h00, 1'b1);
        wait_cs(1'b0, "t6_core_start");
        step(1);
        check_img0("t6_image");
        check_stream0(ws, "t6");
        check("t6_start_once", 32'(cs0_n - cs), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end
endmodule
